// File: rtl/cat_trap_controller.sv
// Cat Trap game sequencer: owns the 8x8 occupancy map, cat and cursor, and
// walks the cat's four neighbours one per cycle after every placed block.
module cat_trap_controller #(
  parameter logic [2:0] CAT_ROW0 = 3'd3,
  parameter logic [2:0] CAT_COL0 = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_select,
  output logic [63:0] blocked,
  output logic [2:0]  cat_row,
  output logic [2:0]  cat_col,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic [2:0]  game_state,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_PLAY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SCAN  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [63:0] blocked_r, blocked_s;
  logic [2:0]  cat_row_r, cat_row_s, cat_col_r, cat_col_s;
  logic [2:0]  cur_row_r, cur_row_s, cur_col_r, cur_col_s;
  logic [1:0]  dir_r, dir_s;
  logic        busy_r;
  logic [2:0]  nb_row_s, nb_col_s;
  logic [5:0]  cur_idx_s, nb_idx_s;
  logic        cur_free_s;

  function automatic logic on_border(input logic [2:0] row, input logic [2:0] col);
    on_border = (row == 3'd0) || (row == 3'd7) || (col == 3'd0) || (col == 3'd7);
  endfunction

  assign cur_idx_s  = {cur_row_r, cur_col_r};
  assign nb_idx_s   = {nb_row_s, nb_col_s};
  assign cur_free_s = !blocked_r[cur_idx_s] &&
                      !((cur_row_r == cat_row_r) && (cur_col_r == cat_col_r));

  // Neighbour under examination for the current scan direction
  always_comb begin
    nb_row_s = cat_row_r;
    nb_col_s = cat_col_r;
    case (dir_r)
      2'd0:    nb_row_s = cat_row_r - 3'd1;
      2'd1:    nb_col_s = cat_col_r + 3'd1;
      2'd2:    nb_row_s = cat_row_r + 3'd1;
      2'd3:    nb_col_s = cat_col_r - 3'd1;
      default: nb_row_s = cat_row_r;
    endcase
  end

  // Game flow next-state and board updates
  always_comb begin
    state_s   = state_r;
    blocked_s = blocked_r;
    cat_row_s = cat_row_r;
    cat_col_s = cat_col_r;
    cur_row_s = cur_row_r;
    cur_col_s = cur_col_r;
    dir_s     = dir_r;
    case (state_r)
      ST_START: begin
        if (btn_select) begin
          blocked_s = 64'd0;
          cat_row_s = CAT_ROW0;
          cat_col_s = CAT_COL0;
          cur_row_s = 3'd0;
          cur_col_s = 3'd0;
          state_s   = ST_PLAY;
        end else begin
          state_s = ST_START;
        end
      end
      ST_PLAY: begin
        // select wins over next; a refused select leaves the cursor put
        if (btn_select) begin
          if (cur_free_s) begin
            blocked_s[cur_idx_s] = 1'b1;
            state_s              = ST_CHECK;
          end else begin
            state_s = ST_PLAY;
          end
        end else if (btn_next) begin
          {cur_row_s, cur_col_s} = cur_idx_s + 6'd1;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_CHECK: begin
        if (on_border(cat_row_r, cat_col_r)) begin
          state_s = ST_OVER;
        end else begin
          dir_s   = 2'd0;
          state_s = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!blocked_r[nb_idx_s]) begin
          cat_row_s = nb_row_s;
          cat_col_s = nb_col_s;
          state_s   = ST_PLAY;
        end else if (dir_r != 2'd3) begin
          dir_s = dir_r + 2'd1;
        end else begin
          state_s = ST_WIN;
        end
      end
      ST_OVER, ST_WIN: begin
        if (btn_select) begin
          state_s = ST_START;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_START;
    endcase
  end

  // State, board and position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_START;
      blocked_r <= 64'd0;
      cat_row_r <= CAT_ROW0;
      cat_col_r <= CAT_COL0;
      cur_row_r <= 3'd0;
      cur_col_r <= 3'd0;
      dir_r     <= 2'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      blocked_r <= blocked_s;
      cat_row_r <= cat_row_s;
      cat_col_r <= cat_col_s;
      cur_row_r <= cur_row_s;
      cur_col_r <= cur_col_s;
      dir_r     <= dir_s;
      busy_r    <= (state_s == ST_CHECK) || (state_s == ST_SCAN);
    end
  end

  assign blocked    = blocked_r;
  assign cat_row    = cat_row_r;
  assign cat_col    = cat_col_r;
  assign cursor_row = cur_row_r;
  assign cursor_col = cur_col_r;
  assign game_state = state_r;
  assign busy       = busy_r;

endmodule
